// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
//   arb_state_t  : arbiter FSM encoding (IDLE -> ISSUE -> WAIT -> IDLE)
//   master_id_t  : master identifier (0 = CPU, 1 = auxiliary DMA/debug loader)
//   TIMEOUT_DATA : read data returned to the owner when an access is aborted
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t MASTER_CPU = 1'b0;
  localparam master_id_t MASTER_AUX = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational two-way winner pick for the memory port arbiter.
// Ports:
//   req     in  2  request vector, bit N = master N
//   rr_last in  1  master that won the previous contended grant
//   winner  out 1  selected master (only meaningful when grant=1)
//   grant   out 1  at least one master is requesting
// FIXED_PRIO != 0 makes master 0 win every contention; otherwise the master
// that did not win the last contention is chosen.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  master_id_t rr_last,
  output master_id_t winner,
  output logic       grant
);

  // Winner selection
  always_comb begin
    winner = MASTER_CPU;
    grant  = |req;
    case (req)
      2'b10:   winner = MASTER_AUX;
      2'b11:   winner = (FIXED_PRIO != 0) ? MASTER_CPU : master_id_t'(~rr_last);
      default: winner = MASTER_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single memory/peripheral port. Master 0 is the
// CPU, master 1 the DMA/debug loader. One access is serviced at a time: the
// winner's command is latched, a one-cycle mem_ce pulse starts the access and
// the completion (valid + read data) is forwarded only to the owner.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a WAIT-state abort after
// TIMEOUT cycles and the m0_err/m1_err outputs.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mN_req/addr/funct3/we/wdata master N command (req held until mN_valid)
//   mN_rdata, mN_valid         read data / one-cycle completion to owner
//   mN_busy                    port owned by the other master or access in flight
//   mN_err                     abort flag with mN_valid (timeout build only)
//   mem_ce/addr/funct3/we/wdata latched command to memory, ce = start pulse
//   mem_rdata, mem_busy, mem_valid memory response
//   owner                      current / last granted master
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [2:0]        m0_funct3,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_valid,
  output logic              m0_busy,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [2:0]        m1_funct3,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_valid,
  output logic              m1_busy,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic              m0_err,
  output logic              m1_err,
`endif
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_funct3,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  input  logic              mem_valid,
  output master_id_t        owner
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  master_id_t        rr_last;
  master_id_t        winner;
  logic              grant;
  logic              launch;
  logic              done;
  logic              timeout_hit;
  logic [DATA_W-1:0] done_data;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  mem_arb_select #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_select (
    .req    ({m1_req, m0_req}),
    .rr_last(rr_last),
    .winner (winner),
    .grant  (grant)
  );

  // An access starts only from IDLE and only while the memory is free
  assign launch    = (state == ARB_IDLE) && grant && !mem_busy;
  assign done      = (state == ARB_WAIT) && (mem_valid || timeout_hit);
  assign done_data = timeout_hit ? DATA_W'(TIMEOUT_DATA) : mem_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (launch) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (done) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Command latch, ownership, round-robin history and per-master read data
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ce     <= 1'b0;
      mem_addr   <= '0;
      mem_funct3 <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      owner      <= MASTER_CPU;
      rr_last    <= MASTER_AUX;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      mem_ce <= launch;
      if (launch) begin
        owner      <= winner;
        mem_addr   <= (winner == MASTER_AUX) ? m1_addr   : m0_addr;
        mem_funct3 <= (winner == MASTER_AUX) ? m1_funct3 : m0_funct3;
        mem_we     <= (winner == MASTER_AUX) ? m1_we     : m0_we;
        mem_wdata  <= (winner == MASTER_AUX) ? m1_wdata  : m0_wdata;
        // History only moves when there was an actual contention
        if (m0_req && m1_req) rr_last <= winner;
      end
      if (m0_valid) m0_rdata_q <= done_data;
      if (m1_valid) m1_rdata_q <= done_data;
    end
  end

  // Completion is forwarded in the same cycle as mem_valid
  assign m0_valid = done && (owner == MASTER_CPU);
  assign m1_valid = done && (owner == MASTER_AUX);
  assign m0_rdata = m0_valid ? done_data : m0_rdata_q;
  assign m1_rdata = m1_valid ? done_data : m1_rdata_q;

  assign m0_busy = (state != ARB_IDLE) || (launch && (winner != MASTER_CPU));
  assign m1_busy = (state != ARB_IDLE) || (launch && (winner != MASTER_AUX));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] tmo_cnt;

  // WAIT-state cycle counter, restarted for every issued access
  always_ff @(posedge clk) begin
    if (reset)                   tmo_cnt <= '0;
    else if (state == ARB_ISSUE) tmo_cnt <= '0;
    else if (state == ARB_WAIT)  tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  // A real completion on the terminal count takes precedence over the abort
  assign timeout_hit = (state == ARB_WAIT) && !mem_valid &&
                       (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign m0_err      = m0_valid && timeout_hit;
  assign m1_err      = m1_valid && timeout_hit;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Two instances share the master
// stimulus: index 0 is round-robin, index 1 is fixed-priority. Each has its
// own memory responder that pulses mem_valid resp_lat cycles after mem_ce.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [2:0]  m0_funct3, m1_funct3;
  logic        m0_we, m1_we;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  logic [31:0] d_m0_rdata[2];
  logic [31:0] d_m1_rdata[2];
  logic [31:0] d_mem_addr[2];
  logic [31:0] d_mem_wdata[2];
  logic [2:0]  d_mem_funct3[2];
  logic [1:0]  d_m0_valid, d_m1_valid, d_m0_busy, d_m1_busy;
  logic [1:0]  d_mem_ce, d_mem_we, d_owner, mem_valid_v;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [1:0]  d_m0_err, d_m1_err;
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .FIXED_PRIO(g),
      .TIMEOUT   (16)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_funct3 (m0_funct3),
      .m0_we     (m0_we),
      .m0_wdata  (m0_wdata),
      .m0_rdata  (d_m0_rdata[g]),
      .m0_valid  (d_m0_valid[g]),
      .m0_busy   (d_m0_busy[g]),
      .m1_req    (m1_req),
      .m1_addr   (m1_addr),
      .m1_funct3 (m1_funct3),
      .m1_we     (m1_we),
      .m1_wdata  (m1_wdata),
      .m1_rdata  (d_m1_rdata[g]),
      .m1_valid  (d_m1_valid[g]),
      .m1_busy   (d_m1_busy[g]),
`ifdef MEM_ARB_TIMEOUT_EN
      .m0_err    (d_m0_err[g]),
      .m1_err    (d_m1_err[g]),
`endif
      .mem_ce    (d_mem_ce[g]),
      .mem_addr  (d_mem_addr[g]),
      .mem_funct3(d_mem_funct3[g]),
      .mem_we    (d_mem_we[g]),
      .mem_wdata (d_mem_wdata[g]),
      .mem_rdata (mem_rdata),
      .mem_busy  (mem_busy),
      .mem_valid (mem_valid_v[g]),
      .owner     (d_owner[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder and grant monitor (acts on the falling edge)
  int   resp_lat   = 3;
  logic resp_en    = 1'b1;
  int   rcnt[2]    = '{0, 0};
  logic ractive[2] = '{1'b0, 1'b0};
  logic gq_rr[$];
  logic gq_fp[$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mem_valid_v[d] = 1'b0;
      if (ractive[d]) begin
        rcnt[d]--;
        if (rcnt[d] == 0) begin
          ractive[d]     = 1'b0;
          mem_valid_v[d] = resp_en;
        end
      end
      if (d_mem_ce[d]) begin
        rcnt[d]    = resp_lat;
        ractive[d] = 1'b1;
        if (d == 0) gq_rr.push_back(d_owner[0]);
        else        gq_fp.push_back(d_owner[1]);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance to the sampling/driving point of the next cycle
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic valid_of(input int d, input logic mid);
    return mid ? d_m1_valid[d] : d_m0_valid[d];
  endfunction

  function automatic logic busy_of(input int d, input logic mid);
    return mid ? d_m1_busy[d] : d_m0_busy[d];
  endfunction

  function automatic logic [31:0] rdata_of(input int d, input logic mid);
    return mid ? d_m1_rdata[d] : d_m0_rdata[d];
  endfunction

  task automatic set_master(input logic mid, input logic req, input logic [31:0] addr,
                            input logic [2:0] f3, input logic we, input logic [31:0] wdata);
    if (mid) begin
      m1_req = req; m1_addr = addr; m1_funct3 = f3; m1_we = we; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_addr = addr; m0_funct3 = f3; m0_we = we; m0_wdata = wdata;
    end
  endtask

  // Steps until master mid of the round-robin instance sees valid (bounded)
  task automatic wait_valid(input logic mid, output logic found, output int n);
    found = 1'b0;
    n     = 0;
    while (n < 64) begin
      step();
      n++;
      if (valid_of(0, mid)) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    logic        mid;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mem_data;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] exp_rd[2];
  logic        found;
  logic        other_seen;
  int          n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0,         3, 32'h1234_5678, 3, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 3'd2, 32'hA5A5_A5A5, 2, 32'h0000_0000, 2, 32'h0000_0000};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0003, 3'd0, 32'h0000_00FF, 1, 32'hCAFE_0000, 1, 32'hCAFE_0000};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0044, 3'd4, 32'h0,         5, 32'h0BAD_F00D, 5, 32'h0BAD_F00D};

    reset = 1'b1;
    mem_rdata = '0;
    mem_busy  = 1'b0;
    set_master(1'b0, 1'b0, '0, '0, 1'b0, '0);
    set_master(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step();
    step();

    // Reset values
    check1("rst mem_ce",   d_mem_ce[0],   1'b0);
    check1("rst mem_we",   d_mem_we[0],   1'b0);
    check("rst mem_addr",  d_mem_addr[0], 32'h0);
    check("rst mem_f3",    32'(d_mem_funct3[0]), 32'h0);
    check("rst mem_wdata", d_mem_wdata[0], 32'h0);
    check1("rst m0_valid", d_m0_valid[0], 1'b0);
    check1("rst m1_valid", d_m1_valid[0], 1'b0);
    check1("rst m0_busy",  d_m0_busy[0],  1'b0);
    check1("rst m1_busy",  d_m1_busy[0],  1'b0);
    check1("rst owner",    d_owner[0],    1'b0);
    reset = 1'b0;
    step();
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Table of single-master accesses
    for (int i = 0; i < 4; i++) begin
      set_master(vecs[i].mid, 1'b1, vecs[i].addr, vecs[i].f3, vecs[i].we, vecs[i].wdata);
      resp_lat  = vecs[i].lat;
      mem_rdata = vecs[i].mem_data;
      step();
      check1($sformatf("v%0d ce", i), d_mem_ce[0], 1'b1);
      check1($sformatf("v%0d owner", i), d_owner[0], vecs[i].mid);
      check($sformatf("v%0d mem_addr", i), d_mem_addr[0], vecs[i].addr);
      check1($sformatf("v%0d mem_we", i), d_mem_we[0], vecs[i].we);
      check($sformatf("v%0d mem_f3", i), 32'(d_mem_funct3[0]), 32'(vecs[i].f3));
      check($sformatf("v%0d mem_wdata", i), d_mem_wdata[0], vecs[i].wdata);
      check1($sformatf("v%0d busy", i), busy_of(0, vecs[i].mid), 1'b1);
      other_seen = 1'b0;
      found      = 1'b0;
      n          = 0;
      while (n < 64 && !found) begin
        step();
        n++;
        if (valid_of(0, !vecs[i].mid)) other_seen = 1'b1;
        if (valid_of(0, vecs[i].mid)) found = 1'b1;
      end
      check1($sformatf("v%0d valid seen", i), found, 1'b1);
      check($sformatf("v%0d latency", i), 32'(n), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d rdata", i), rdata_of(0, vecs[i].mid), vecs[i].exp_rdata);
      check1($sformatf("v%0d other valid", i), other_seen, 1'b0);
      check($sformatf("v%0d addr stable", i), d_mem_addr[0], vecs[i].addr);
      set_master(vecs[i].mid, 1'b0, '0, '0, 1'b0, '0);
      step();
      mem_rdata = 32'hFFFF_0000;
      exp_rd[vecs[i].mid] = vecs[i].exp_rdata;
      check1($sformatf("v%0d valid pulse", i), valid_of(0, vecs[i].mid), 1'b0);
      check($sformatf("v%0d rdata held", i), rdata_of(0, vecs[i].mid), exp_rd[vecs[i].mid]);
      check($sformatf("v%0d other rdata", i), rdata_of(0, !vecs[i].mid), exp_rd[!vecs[i].mid]);
    end

    // mem_busy holds off the grant
    mem_busy = 1'b1;
    resp_lat = 2;
    set_master(1'b0, 1'b1, 32'h40, 3'd2, 1'b0, '0);
    step();
    check1("mbusy ce0", d_mem_ce[0], 1'b0);
    check1("mbusy m0_busy", d_m0_busy[0], 1'b0);
    step();
    check1("mbusy ce1", d_mem_ce[0], 1'b0);
    mem_busy = 1'b0;
    step();
    check1("mbusy ce after release", d_mem_ce[0], 1'b1);
    wait_valid(1'b0, found, n);
    check1("mbusy valid seen", found, 1'b1);
    set_master(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step();

    // Contention: both held from a fresh reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    gq_rr.delete();
    gq_fp.delete();
    resp_lat = 2;
    set_master(1'b0, 1'b1, 32'h1000, 3'd2, 1'b0, '0);
    set_master(1'b1, 1'b1, 32'h1004, 3'd2, 1'b0, '0);
    #1;
    check1("both rr m0_busy", d_m0_busy[0], 1'b0);
    check1("both rr m1_busy", d_m1_busy[0], 1'b1);
    check1("both fp m1_busy", d_m1_busy[1], 1'b1);
    n = 0;
    while (n < 60 && (gq_rr.size() < 4 || gq_fp.size() < 4)) begin
      step();
      n++;
    end
    check1("rr 4 grants", gq_rr.size() >= 4, 1'b1);
    check1("fp 4 grants", gq_fp.size() >= 4, 1'b1);
    if (gq_rr.size() >= 4 && gq_fp.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check1($sformatf("rr grant %0d", i), gq_rr[i], 1'(i % 2));
        check1($sformatf("fp grant %0d", i), gq_fp[i], 1'b0);
      end
    end
    m0_req = 1'b0;
    gq_fp.delete();
    n = 0;
    while (n < 30 && gq_fp.size() < 1) begin
      step();
      n++;
    end
    check1("fp m1 granted", gq_fp.size() >= 1, 1'b1);
    if (gq_fp.size() >= 1) check1("fp m1 owner", gq_fp[0], 1'b1);
    m1_req = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // m1 write in flight, m0 arrives during WAIT
    resp_lat  = 4;
    mem_rdata = 32'h0;
    set_master(1'b1, 1'b1, 32'h2000, 3'd2, 1'b1, 32'hA5A5_A5A5);
    step();
    check1("w ce", d_mem_ce[0], 1'b1);
    check1("w owner", d_owner[0], 1'b1);
    step();
    set_master(1'b0, 1'b1, 32'h500, 3'd2, 1'b0, '0);
    #1;
    check1("w m0_busy wait", d_m0_busy[0], 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check1($sformatf("w ce low %0d", i), d_mem_ce[0], 1'b0);
      check($sformatf("w addr stable %0d", i), d_mem_addr[0], 32'h2000);
      check($sformatf("w wdata stable %0d", i), d_mem_wdata[0], 32'hA5A5_A5A5);
      check1($sformatf("w we stable %0d", i), d_mem_we[0], 1'b1);
      check1($sformatf("w m0_busy %0d", i), d_m0_busy[0], 1'b1);
    end
    step();
    check1("w m1_valid", d_m1_valid[0], 1'b1);
    check1("w m0_valid", d_m0_valid[0], 1'b0);
    m1_req    = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    step();
    check1("w idle gap ce", d_mem_ce[0], 1'b0);
    check1("w idle m0_busy", d_m0_busy[0], 1'b0);
    step();
    check1("w m0 ce", d_mem_ce[0], 1'b1);
    check1("w m0 owner", d_owner[0], 1'b0);
    check("w m0 addr", d_mem_addr[0], 32'h500);
    wait_valid(1'b0, found, n);
    check1("w m0 valid seen", found, 1'b1);
    check("w m0 rdata", d_m0_rdata[0], 32'h5555_AAAA);
    m0_req = 1'b0;
    step();

    // Request dropped after issue still completes
    resp_lat  = 3;
    mem_rdata = 32'h7777_0001;
    set_master(1'b1, 1'b1, 32'h60, 3'd2, 1'b0, '0);
    step();
    check1("drop ce", d_mem_ce[0], 1'b1);
    m1_req = 1'b0;
    wait_valid(1'b1, found, n);
    check1("drop valid seen", found, 1'b1);
    check("drop rdata", d_m1_rdata[0], 32'h7777_0001);
    step();

    // Reset in the middle of WAIT
    resp_lat = 3;
    set_master(1'b1, 1'b1, 32'h80, 3'd2, 1'b1, 32'h99);
    step();
    check1("rw ce", d_mem_ce[0], 1'b1);
    step();
    reset  = 1'b1;
    m1_req = 1'b0;
    step();
    check1("rw ce after reset", d_mem_ce[0], 1'b0);
    check("rw addr after reset", d_mem_addr[0], 32'h0);
    check1("rw we after reset", d_mem_we[0], 1'b0);
    check1("rw owner after reset", d_owner[0], 1'b0);
    check1("rw m1_busy after reset", d_m1_busy[0], 1'b0);
    reset = 1'b0;
    step();
    check1("rw late m1_valid", d_m1_valid[0], 1'b0);
    check1("rw late m0_valid", d_m0_valid[0], 1'b0);
    step();
    check1("rw ce quiet", d_mem_ce[0], 1'b0);
    check1("rw m0_busy quiet", d_m0_busy[0], 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Abort after TIMEOUT cycles without a response
    resp_en = 1'b0;
    set_master(1'b0, 1'b1, 32'h90, 3'd2, 1'b0, '0);
    step();
    check1("to ce", d_mem_ce[0], 1'b1);
    wait_valid(1'b0, found, n);
    check1("to valid seen", found, 1'b1);
    check("to latency", 32'(n), 32'd16);
    check1("to m0_err", d_m0_err[0], 1'b1);
    check1("to m1_err", d_m1_err[0], 1'b0);
    check("to rdata", d_m0_rdata[0], 32'hDEAD_BEEF);
    m0_req = 1'b0;
    step();
    check1("to err pulse", d_m0_err[0], 1'b0);
    check("to rdata held", d_m0_rdata[0], 32'hDEAD_BEEF);

    // Response exactly on the terminal count is a normal completion
    resp_en   = 1'b1;
    resp_lat  = 16;
    mem_rdata = 32'h0000_600D;
    set_master(1'b0, 1'b1, 32'h94, 3'd2, 1'b0, '0);
    step();
    wait_valid(1'b0, found, n);
    check1("tc valid seen", found, 1'b1);
    check("tc latency", 32'(n), 32'd16);
    check1("tc m0_err", d_m0_err[0], 1'b0);
    check("tc rdata", d_m0_rdata[0], 32'h0000_600D);
    m0_req = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
